// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor for the butterfly datapath.
//
// The carry chain is cut into NSEG registered segments of SEGW = WIDTH/NSEG bits.
// Each segment is a two-level lookahead adder. The first level forms the GRP-bit
// group generate/propagate. The second level forms the group carries.
// Operands for upper segments travel down a skew pipeline. Each pipeline stage
// shifts them right by SEGW, so the segment a stage needs always sits in bits
// [SEGW-1:0]. Finished low result bits ride along in the result register, which
// deskews them so that all WIDTH bits leave together. Latency is NSEG enabled
// cycles, and one operation is accepted per enabled cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         pipeline enable; 0 freezes all state and outputs
//   in_valid   operands valid this cycle
//   sub        0: a+b+c_in, 1: a-b (a+~b+1, c_in ignored)
//   a_in, b_in operands
//   c_in       carry-in (add mode only)
//   sum        result modulo 2^WIDTH
//   c_out      carry out of MSB (sub mode: 1 = no borrow)
//   ovf        two's-complement overflow
//   out_valid  sum/c_out/ovf valid
module cla_pipe_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GRP   = 4,
  parameter int unsigned NSEG  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             out_valid
);

  localparam int unsigned SEGW = WIDTH / NSEG;
  localparam int unsigned NGRP = SEGW / GRP;

  if ((NSEG == 0) || (GRP == 0) || ((WIDTH % (NSEG * GRP)) != 0)) begin : g_param_err
    $error("cla_pipe_addsub: WIDTH must be a nonzero multiple of NSEG*GRP");
  end

  // Returns {carry_out, overflow, sum} for one segment.
  // Overflow is the carry into the segment MSB XOR the carry out of the segment.
  function automatic logic [SEGW+1:0] seg_add(input logic [SEGW-1:0] a,
                                              input logic [SEGW-1:0] b,
                                              input logic            cin);
    logic [SEGW-1:0] g, p, c;
    logic [NGRP-1:0] grp_g, grp_p;
    logic [NGRP:0]   grp_c;
    logic            t;
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    // First level: group generate/propagate, written as flat product terms.
    for (int j = 0; j < NGRP; j++) begin
      grp_p[j] = &p[j*GRP +: GRP];
      for (int m = 0; m < GRP; m++) begin
        t = g[j*GRP+m];
        for (int l = m + 1; l < GRP; l++) t = t & p[j*GRP+l];
        grp_g[j] = grp_g[j] | t;
      end
    end
    // Second level: every group carry is a direct function of cin and the group G/P.
    for (int j = 0; j <= NGRP; j++) begin
      t = cin;
      for (int l = 0; l < j; l++) t = t & grp_p[l];
      grp_c[j] = t;
      for (int m = 0; m < j; m++) begin
        t = grp_g[m];
        for (int l = m + 1; l < j; l++) t = t & grp_p[l];
        grp_c[j] = grp_c[j] | t;
      end
    end
    // Bit carries inside a group depend only on that group's carry-in.
    for (int j = 0; j < NGRP; j++) begin
      for (int i = 0; i < GRP; i++) begin
        t = grp_c[j];
        for (int l = 0; l < i; l++) t = t & p[j*GRP+l];
        c[j*GRP+i] = t;
        for (int m = 0; m < i; m++) begin
          t = g[j*GRP+m];
          for (int l = m + 1; l < i; l++) t = t & p[j*GRP+l];
          c[j*GRP+i] = c[j*GRP+i] | t;
        end
      end
    end
    return {grp_c[NGRP], grp_c[NGRP] ^ c[SEGW-1], p ^ c};
  endfunction

  // Stage inputs: operands with this stage's segment in the LSBs.
  logic [WIDTH-1:0] op_a   [NSEG];
  logic [WIDTH-1:0] op_b   [NSEG];
  logic [WIDTH-1:0] res_in [NSEG];
  logic [NSEG-1:0]  cin_stage;
  logic [NSEG-1:0]  vld_in;

  // Next-state and registered state per stage.
  logic [WIDTH-1:0] res_d    [NSEG];
  logic [WIDTH-1:0] res_q    [NSEG];
  logic [WIDTH-1:0] skew_a_d [NSEG];
  logic [WIDTH-1:0] skew_a_q [NSEG];
  logic [WIDTH-1:0] skew_b_d [NSEG];
  logic [WIDTH-1:0] skew_b_q [NSEG];
  logic [NSEG-1:0]  cy_d, cy_q;
  logic [NSEG-1:0]  ovf_d, ovf_q;
  logic [NSEG-1:0]  vld_q;

  always_comb begin
    op_a[0]      = a_in;
    op_b[0]      = sub ? ~b_in : b_in;
    cin_stage    = '0;
    cin_stage[0] = sub | c_in;
    res_in[0]    = '0;
    vld_in       = '0;
    vld_in[0]    = in_valid;
    for (int k = 1; k < NSEG; k++) begin
      op_a[k]      = skew_a_q[k-1];
      op_b[k]      = skew_b_q[k-1];
      res_in[k]    = res_q[k-1];
      cin_stage[k] = cy_q[k-1];
      vld_in[k]    = vld_q[k-1];
    end
  end

  always_comb begin
    logic [SEGW+1:0] r;
    r     = '0;
    cy_d  = '0;
    ovf_d = '0;
    for (int k = 0; k < NSEG; k++) begin
      r           = seg_add(op_a[k][SEGW-1:0], op_b[k][SEGW-1:0], cin_stage[k]);
      res_d[k]    = res_in[k] | (WIDTH'(r[SEGW-1:0]) << (k * SEGW));
      cy_d[k]     = r[SEGW+1];
      ovf_d[k]    = r[SEGW];
      skew_a_d[k] = op_a[k] >> SEGW;
      skew_b_d[k] = op_b[k] >> SEGW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) begin
        res_q[k]    <= '0;
        skew_a_q[k] <= '0;
        skew_b_q[k] <= '0;
      end
      cy_q  <= '0;
      ovf_q <= '0;
      vld_q <= '0;
    end else if (en) begin
      for (int k = 0; k < NSEG; k++) begin
        res_q[k]    <= res_d[k];
        skew_a_q[k] <= skew_a_d[k];
        skew_b_q[k] <= skew_b_d[k];
      end
      cy_q  <= cy_d;
      ovf_q <= ovf_d;
      vld_q <= vld_in;
    end
  end

  assign sum       = res_q[NSEG-1];
  assign c_out     = cy_q[NSEG-1];
  assign ovf       = ovf_q[NSEG-1];
  assign out_valid = vld_q[NSEG-1];

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub. Two instances are driven side by side:
//   - 32-bit / 2 segments
//   - 64-bit / 4 segments
// A queue-style reference model computes results with plain integer arithmetic.
module tb_cla_pipe_addsub;
  localparam int L1 = 2;
  localparam int L2 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        c_in = 1'b0;
  logic [31:0] a1 = '0, b1 = '0;
  logic [63:0] a2 = '0, b2 = '0;
  logic [31:0] sum1;
  logic [63:0] sum2;
  logic        c1, o1, v1, c2, o2, v2;

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(32), .GRP(4), .NSEG(2)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub),
    .a_in(a1), .b_in(b1), .c_in(c_in),
    .sum(sum1), .c_out(c1), .ovf(o1), .out_valid(v1)
  );

  cla_pipe_addsub #(.WIDTH(64), .GRP(4), .NSEG(4)) dut64 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub),
    .a_in(a2), .b_in(b2), .c_in(c_in),
    .sum(sum2), .c_out(c2), .ovf(o2), .out_valid(v2)
  );

  typedef struct packed {
    logic        v;
    logic        rz;  // slot is known-zero from reset
    logic [63:0] s;
    logic        c;
    logic        o;
  } slot_t;

  slot_t m1 [L1];
  slot_t m2 [L2];
  int    n_checks = 0;
  int    n_err = 0;

  // Returns {ovf, carry, sum} for a w-bit operation.
  function automatic logic [65:0] ref_op(int w, logic sb, logic [63:0] a, logic [63:0] b,
                                         logic ci);
    logic [64:0] mask, full;
    logic [63:0] be, s;
    logic        cy, ov, cin;
    mask = (65'd1 << w) - 65'd1;
    be   = sb ? ~b : b;
    be   = be & mask[63:0];
    cin  = sb ? 1'b1 : ci;
    full = ({1'b0, a} & mask) + {1'b0, be} + {64'd0, cin};
    s    = full[63:0] & mask[63:0];
    cy   = full[w];
    ov   = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
    return {ov, cy, s};
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [65:0] r;
    if (rst) begin
      for (int i = 0; i < L1; i++) begin m1[i] = '0; m1[i].rz = 1'b1; end
      for (int i = 0; i < L2; i++) begin m2[i] = '0; m2[i].rz = 1'b1; end
    end else if (en) begin
      for (int i = L1 - 1; i > 0; i--) m1[i] = m1[i-1];
      for (int i = L2 - 1; i > 0; i--) m2[i] = m2[i-1];
      r     = ref_op(32, sub, {32'd0, a1}, {32'd0, b1}, c_in);
      m1[0] = {in_valid, 1'b0, r[63:0], r[64], r[65]};
      r     = ref_op(64, sub, a2, b2, c_in);
      m2[0] = {in_valid, 1'b0, r[63:0], r[64], r[65]};
    end
  end

  task automatic check_slot(string nm, slot_t e, logic v, logic [63:0] s, logic c, logic o);
    logic ok;
    ok = (v === e.v);
    if (e.v) ok = ok && (s === e.s) && (c === e.c) && (o === e.o);
    if (e.rz) ok = ok && (s === 64'd0) && (c === 1'b0) && (o === 1'b0);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s t=%0t: got v=%b s=%h c=%b o=%b, expected v=%b s=%h c=%b o=%b rz=%b",
               nm, $time, v, s, c, o, e.v, e.s, e.c, e.o, e.rz);
    end
  endtask

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    check_slot("stream32", m1[L1-1], v1, 64'(sum1), c1, o1);
    check_slot("stream64", m2[L2-1], v2, sum2, c2, o2);
  end

  task automatic drive(logic v, logic sb, logic [31:0] a, logic [31:0] b, logic ci,
                       logic [63:0] aw, logic [63:0] bw);
    in_valid = v;
    sub      = sb;
    a1       = a;
    b1       = b;
    c_in     = ci;
    a2       = aw;
    b2       = bw;
  endtask

  function automatic logic [31:0] rnd32();
    logic [31:0] pick [4];
    pick[0] = 32'h0000_0000;
    pick[1] = 32'hFFFF_FFFF;
    pick[2] = 32'h8000_0000;
    pick[3] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return pick[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  typedef struct {
    logic        sb;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [31:0] snap_s1;
    logic [63:0] snap_s2;
    logic [3:0]  snap_f;
    int          seen;

    tbl[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 32'h0000_0007, 32'h0000_0005, 1'b0, 32'h0000_0002, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0000_FFFF, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_sum", 64'(sum1), 64'd0);
    chk("reset_flags", {60'd0, c1, o1, v1, v2}, 64'd0);
    #2 rst = 1'b0;
    en = 1'b1;

    // Directed vectors, one at a time: valid for exactly one cycle after 2.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, tbl[i].sb, tbl[i].a, tbl[i].b, tbl[i].ci,
            {tbl[i].a, tbl[i].b}, {tbl[i].b, tbl[i].a});
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_result", i), {29'd0, v1, c1, o1, sum1},
          {29'd0, 1'b1, tbl[i].ec, tbl[i].eo, tbl[i].es});
      @(negedge clk);
      chk($sformatf("vec%0d_single", i), 64'(v1), 64'd0);
    end
    repeat (3) @(negedge clk);

    // Streaming: a bubble at slot 3 and a three-cycle stall from slot 5.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 5) begin
        snap_s1 = sum1;
        snap_s2 = sum2;
        snap_f  = {c1, o1, c2, o2};
        en      = 1'b0;
      end else if (i >= 6 && i <= 8) begin
        chk($sformatf("stall%0d_sum32", i), 64'(sum1), 64'(snap_s1));
        chk($sformatf("stall%0d_sum64", i), sum2, snap_s2);
        chk($sformatf("stall%0d_flags", i), 64'({c1, o1, c2, o2}), 64'(snap_f));
        if (i == 8) en = 1'b1;
      end
      drive(i != 3, 1'($urandom), rnd32(), rnd32(), 1'($urandom),
            {rnd32(), rnd32()}, {rnd32(), rnd32()});
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Random traffic with random enable and bubbles.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      en = ($urandom_range(0, 9) != 0);
      drive($urandom_range(0, 4) != 0, 1'($urandom), rnd32(), rnd32(), 1'($urandom),
            {rnd32(), rnd32()}, {rnd32(), rnd32()});
    end
    @(negedge clk);
    en = 1'b1;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Reset with two operations in flight.
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h5, 32'h7, 1'b0, 64'h5, 64'h7);
    @(posedge clk);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_sum32", 64'(sum1), 64'd0);
    chk("midrst_sum64", sum2, 64'd0);
    chk("midrst_flags", {58'd0, c1, o1, v1, c2, o2, v2}, 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (v1 || v2) seen++;
    end
    chk("post_reset_no_valid", 64'(seen), 64'd0);

    // A fresh operation still flows after the reset.
    drive(1'b1, 1'b0, 32'h0000_FFFF, 32'h0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_op", {31'd0, v1, sum1}, {31'd0, 1'b1, 32'h0001_0000});
    repeat (4) @(negedge clk);
    chk("post_reset_op64", sum2, 64'h0000_0001_0000_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the butterfly datapath.
- Generalises the fixed 2-bit lookahead cell:
  - any operand width, built from GRP-bit lookahead groups.
  - carry chain split into NSEG registered segments, so wide sums close timing at the FFT clock.
  - add/sub mode, external carry-in, signed-overflow flag.
  - valid/enable pipeline control.
- Sits between the twiddle multiplier output and the butterfly output registers; full throughput of one operation per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of NSEG*GRP.
- GRP, 4, lookahead group width; each group produces group generate/propagate, combined by a second lookahead level within a segment.
- NSEG, 2, number of pipeline segments (≥1); SEGW = WIDTH/NSEG bits are resolved per stage; latency = NSEG cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  pipeline enable; 0 freezes every internal register and output.
- in_valid  input  1  operands valid this cycle.
- sub  input  1  0: a+b+c_in; 1: a−b computed as a+~b+1; c_in ignored.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- c_in  input  1  carry-in, add mode only.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- c_out  output  1  carry out of MSB; in sub mode 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  sum/c_out/ovf valid.

Behaviour:
- Reset (asynchronous on rst rising, held while rst=1):
  - all pipeline registers clear; sum=0, c_out=0, ovf=0, out_valid=0.
  - Release is synchronous to clk; the first capture is at the first rising edge with rst=0 and en=1.
- Input stage:
  - b_eff = sub ? ~b_in : b_in.
  - cin_eff = sub ? 1 : c_in.
  - Computed combinationally at the input.
- Stage k (k = 0..NSEG−1) resolves bits [k*SEGW +: SEGW]:
  - Uses the registered carry from stage k−1; stage 0 uses cin_eff.
  - Within a segment: bitwise g = a&b, p = a^b; GRP-bit groups form group G/P; a second-level lookahead forms group carries; sum bits = p ^ carry.
  - No ripple across more than one group inside the lookahead logic.
- Operand skew:
  - Upper segments' operand bits are delayed through skew registers so every segment of one operation meets its carry in the correct stage.
  - Lower-segment results are delayed (deskew) so all WIDTH bits leave together.
- Latency and throughput:
  - Latency is exactly NSEG enabled cycles from the in_valid capture to out_valid.
  - One new operation is accepted per enabled cycle; back-to-back operations never interact.
- Enable:
  - en=0: no register updates, including valid bits; outputs hold.
  - en has priority over in_valid.
- Valid handling:
  - in_valid=0 on an enabled cycle inserts a bubble (valid bit 0).
  - Data registers are still allowed to load, but out_valid=0 for that slot.
  - sum is don't-care when out_valid=0 except after reset (0).
- Flags:
  - c_out = carry out of bit WIDTH−1.
  - ovf = carry into bit WIDTH−1 XOR c_out.
  - Both are registered alongside sum.
- NSEG=1: a single registered stage, latency 1.
- Reset mid-operation: in-flight operations are discarded; no out_valid is produced for them after release.
- Illegal parameters (WIDTH % (NSEG*GRP) ≠ 0): elaboration-time error.

Test Plan:
- Carry across the segment boundary:
  - Stimulus: add, a=0xFFFFFFFF, b=0x00000001, c_in=0.
  - Response: after 2 cycles sum=0x00000000, c_out=1, ovf=0, out_valid=1 for one cycle.
- Subtract with borrow:
  - Stimulus: sub=1, a=5, b=7.
  - Response: sum=0xFFFFFFFE, c_out=0, ovf=0.
  - Then a=7, b=5 → sum=0x00000002, c_out=1.
- Signed overflow:
  - 0x7FFFFFFF+0x00000001 → sum=0x80000000, ovf=1, c_out=0.
  - Sub 0x80000000−1 → sum=0x7FFFFFFF, ovf=1.
- Carry-in:
  - Add a=0x0000FFFF, b=0, c_in=1 → sum=0x00010000.
  - Same operands with sub=1 → c_in ignored, sum=0x0000FFFF, c_out=1.
- Streaming and stall:
  - Stimulus: 8 back-to-back random operations with en dropped for 3 cycles mid-stream and one in_valid=0 bubble.
  - Response: results match the reference model in order, latency 2 enabled cycles, outputs frozen during the stall, out_valid=0 in the bubble slot.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously while 2 operations are in flight.
  - Response: outputs are 0 immediately; no out_valid after release until new inputs are issued.
  - Repeat the streaming test with NSEG=4, WIDTH=64, GRP=4.
